// File: rtl/pislip_sched_v2_pkg.sv
// Shared definitions for the prioritised iSLIP scheduler.
//   state_t  : scheduler FSM encoding
//   clog2    : elaboration-time ceiling log2
//   req_idx  : flat bit position of a (input, level, output) request
package pislip_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int req_idx(input int in_i, input int p, input int out_i,
                                  input int no, input int np);
      return in_i * no * np + p * no + out_i;
   endfunction

endpackage

// File: rtl/pislip_sched_v2_if.sv
// Request/result bundle between the VOQ status logic (master) and the
// scheduler (slave).
//   i_start/i_iter              : schedule launch and iteration budget
//   i_request/i_*_idle          : per-pair, per-level requests and port masks
//   o_busy/o_valid              : schedule in progress / one-cycle result strobe
//   o_match/o_match_pri/o_iter_used : result of the last schedule
interface pislip_sched_v2_if #(
   parameter int NI = 12,
   parameter int NO = 12,
   parameter int P  = 8,
   parameter int PW = 3,
   parameter int IW = 3
);
   logic                 i_start;
   logic [IW-1:0]        i_iter;
   logic [NI*NO*P-1:0]   i_request;
   logic [NI-1:0]        i_input_idle;
   logic [NO-1:0]        i_output_idle;
   logic                 o_busy;
   logic                 o_valid;
   logic [NI*NO-1:0]     o_match;
   logic [NI*PW-1:0]     o_match_pri;
   logic [IW-1:0]        o_iter_used;

   modport master (
      output i_start, i_iter, i_request, i_input_idle, i_output_idle,
      input  o_busy, o_valid, o_match, o_match_pri, o_iter_used
   );

   modport slave (
      input  i_start, i_iter, i_request, i_input_idle, i_output_idle,
      output o_busy, o_valid, o_match, o_match_pri, o_iter_used
   );
endinterface

// File: rtl/pislip_sched_v2_arb.sv
// Priority round-robin arbiter: highest level wins, ties broken by the first
// requester at index >= ptr (wrapping).
//   req     : W request bits
//   lvl     : W packed levels, PW bits each
//   ptr     : round-robin start index
//   gnt     : one-hot winner (0 when no request)
//   win_lvl : level of the winner
module prio_rr_arbiter
   import pislip_pkg::*;
#(
   parameter int W = 12,
   parameter int P = 8,
   localparam int PW   = (clog2(P) < 1) ? 1 : clog2(P),
   localparam int PTRW = (clog2(W) < 1) ? 1 : clog2(W)
) (
   input  logic [W-1:0]    req,
   input  logic [W*PW-1:0] lvl,
   input  logic [PTRW-1:0] ptr,
   output logic [W-1:0]    gnt,
   output logic [PW-1:0]   win_lvl
);

   logic [PW-1:0] best;
   logic [W-1:0]  cand;
   logic          found;
   int            idx;

   always_comb begin
      best  = '0;
      cand  = '0;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < W; i++)
         if (req[i] && (lvl[i*PW +: PW] > best)) best = lvl[i*PW +: PW];
      for (int i = 0; i < W; i++)
         cand[i] = req[i] && (lvl[i*PW +: PW] == best);
      // walk from ptr once around the ring, first candidate wins
      for (int k = 0; k < W; k++) begin
         idx = int'(ptr) + k;
         if (idx >= W) idx = idx - W;
         if (!found && cand[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      win_lvl = best;
   end

endmodule

// File: rtl/pislip_sched_v2.sv
// Prioritised iSLIP crossbar scheduler, NI inputs x NO outputs, runtime
// iteration count, persistent grant/accept pointers.
//   clk, reset (async, active low)
//   bus : slave side of pislip_sched_v2_if (start/valid handshake, requests,
//         idle masks, match result)
//
// state   | meaning
// ST_IDLE | waiting for i_start; o_valid may pulse here
// ST_ITER | one request/grant/accept iteration per cycle
module pislip_sched_v2
   import pislip_pkg::*;
#(
   parameter int NI       = 12,
   parameter int NO       = 12,
   parameter int P        = 8,
   parameter int PW       = 3,
   parameter int MAX_ITER = 4,
   parameter int IW       = 3
) (
   input logic              clk,
   input logic              reset,
   pislip_sched_v2_if.slave bus
);

   localparam int GPW = (clog2(NI) < 1) ? 1 : clog2(NI);
   localparam int APW = (clog2(NO) < 1) ? 1 : clog2(NO);

   state_t state, state_nx;
   logic   busy, start_acc;

   logic [NI*NO*P-1:0] req_q, req_mask;
   logic [IW-1:0]      n_q, iter_q, n_clamp;
   logic [NI-1:0]      in_m, in_m_nx;
   logic [NO-1:0]      out_m, out_m_nx;
   logic [NI*NO-1:0]   match_q, match_nx;
   logic [NI*PW-1:0]   pri_q, pri_nx;
   logic [GPW-1:0]     g_ptr [NO];
   logic [APW-1:0]     a_ptr [NI];

   logic [PW-1:0]      pl     [NI][NO];
   logic [NO-1:0]      rq_any [NI];
   logic [NI-1:0]      g_req  [NO];
   logic [NI*PW-1:0]   g_lvl  [NO];
   logic [NI-1:0]      g_gnt  [NO];
   logic [PW-1:0]      g_win  [NO];
   logic [NO-1:0]      a_req  [NI];
   logic [NO*PW-1:0]   a_lvl  [NI];
   logic [NO-1:0]      a_gnt  [NI];
   logic [PW-1:0]      a_win  [NI];
   logic               rem, done;

   logic               valid_q;
   logic [NI*NO-1:0]   res_match;
   logic [NI*PW-1:0]   res_pri;
   logic [IW-1:0]      res_iter;

   always_comb begin
      if (bus.i_iter == '0)                 n_clamp = IW'(1);
      else if (bus.i_iter > IW'(MAX_ITER))  n_clamp = IW'(MAX_ITER);
      else                                  n_clamp = bus.i_iter;
   end

   always_comb begin
      req_mask = '0;
      for (int i = 0; i < NI; i++)
         for (int p = 0; p < P; p++)
            for (int o = 0; o < NO; o++)
               req_mask[req_idx(i, p, o, NO, P)] = bus.i_request[req_idx(i, p, o, NO, P)]
                                                   & bus.i_input_idle[i] & bus.i_output_idle[o];
   end

   // effective level per pair and grant-side request vectors
   always_comb begin
      for (int i = 0; i < NI; i++) begin
         rq_any[i] = '0;
         for (int o = 0; o < NO; o++) pl[i][o] = '0;
      end
      for (int o = 0; o < NO; o++) begin
         g_req[o] = '0;
         g_lvl[o] = '0;
      end
      for (int i = 0; i < NI; i++)
         for (int o = 0; o < NO; o++) begin
            for (int p = 0; p < P; p++)
               if (req_q[req_idx(i, p, o, NO, P)]) begin
                  pl[i][o]     = PW'(p);
                  rq_any[i][o] = 1'b1;
               end
            g_req[o][i]            = rq_any[i][o] & ~in_m[i] & ~out_m[o];
            g_lvl[o][i*PW +: PW]   = pl[i][o];
         end
   end

   for (genvar o = 0; o < NO; o++) begin : g_grant
      prio_rr_arbiter #(.W(NI), .P(P)) u_arb (
         .req(g_req[o]), .lvl(g_lvl[o]), .ptr(g_ptr[o]),
         .gnt(g_gnt[o]), .win_lvl(g_win[o])
      );
   end

   always_comb begin
      for (int i = 0; i < NI; i++) begin
         a_req[i] = '0;
         a_lvl[i] = '0;
         for (int o = 0; o < NO; o++) begin
            a_req[i][o]          = g_gnt[o][i];
            a_lvl[i][o*PW +: PW] = g_win[o];
         end
      end
   end

   for (genvar i = 0; i < NI; i++) begin : g_accept
      prio_rr_arbiter #(.W(NO), .P(P)) u_arb (
         .req(a_req[i]), .lvl(a_lvl[i]), .ptr(a_ptr[i]),
         .gnt(a_gnt[i]), .win_lvl(a_win[i])
      );
   end

   always_comb begin
      match_nx = match_q;
      pri_nx   = pri_q;
      in_m_nx  = in_m;
      out_m_nx = out_m;
      rem      = 1'b0;
      for (int i = 0; i < NI; i++)
         for (int o = 0; o < NO; o++)
            if (a_gnt[i][o]) begin
               match_nx[i*NO + o]    = 1'b1;
               pri_nx[i*PW +: PW]    = a_win[i];
               in_m_nx[i]            = 1'b1;
               out_m_nx[o]           = 1'b1;
            end
      for (int i = 0; i < NI; i++)
         for (int o = 0; o < NO; o++)
            if (rq_any[i][o] && !in_m_nx[i] && !out_m_nx[o]) rem = 1'b1;
      done = (iter_q >= n_q) || !rem || (&in_m_nx) || (&out_m_nx);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (bus.i_start) state_nx = ST_ITER;
         ST_ITER: if (done)        state_nx = ST_IDLE;
         default:                  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ST_ITER);
      start_acc = (state == ST_IDLE) && bus.i_start;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q     <= '0;
         n_q       <= '0;
         iter_q    <= '0;
         in_m      <= '0;
         out_m     <= '0;
         match_q   <= '0;
         pri_q     <= '0;
         valid_q   <= 1'b0;
         res_match <= '0;
         res_pri   <= '0;
         res_iter  <= '0;
         for (int o = 0; o < NO; o++) g_ptr[o] <= '0;
         for (int i = 0; i < NI; i++) a_ptr[i] <= '0;
      end else begin
         valid_q <= 1'b0;
         if (start_acc) begin
            req_q   <= req_mask;
            n_q     <= n_clamp;
            iter_q  <= IW'(1);
            in_m    <= '0;
            out_m   <= '0;
            match_q <= '0;
            pri_q   <= '0;
         end else if (busy) begin
            match_q <= match_nx;
            pri_q   <= pri_nx;
            in_m    <= in_m_nx;
            out_m   <= out_m_nx;
            iter_q  <= iter_q + 1'b1;
            // pointers only move on first-iteration accepts (keeps iSLIP desynchronisation)
            if (iter_q == IW'(1))
               for (int i = 0; i < NI; i++)
                  for (int o = 0; o < NO; o++)
                     if (a_gnt[i][o]) begin
                        g_ptr[o] <= GPW'((i + 1) % NI);
                        a_ptr[i] <= APW'((o + 1) % NO);
                     end
            if (done) begin
               valid_q   <= 1'b1;
               res_match <= match_nx;
               res_pri   <= pri_nx;
               res_iter  <= iter_q;
            end
         end
      end
   end

   assign bus.o_busy      = busy;
   assign bus.o_valid     = valid_q;
   assign bus.o_match     = res_match;
   assign bus.o_match_pri = res_pri;
   assign bus.o_iter_used = res_iter;

endmodule

// File: tb/tb_pislip_sched_v2.sv
// Self-checking bench for pislip_sched_v2 (4x4, 4 levels): directed
// scenarios with hand-derived results plus random schedules checked against
// a loop-based reference model through a result scoreboard.
module tb_pislip_sched_v2;

   localparam int NI = 4, NO = 4, P = 4, PW = 2, MAX_ITER = 4, IW = 3;
   localparam logic [63:0] ALL0 = 64'h000F_000F_000F_000F;

   typedef struct packed {
      logic [15:0] m;
      logic [7:0]  pr;
      logic [2:0]  it;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pislip_sched_v2_if #(.NI(NI), .NO(NO), .P(P), .PW(PW), .IW(IW)) bus ();

   pislip_sched_v2 #(.NI(NI), .NO(NO), .P(P), .PW(PW), .MAX_ITER(MAX_ITER), .IW(IW)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   exp_t sb_q[$];
   int   n_tests = 0, n_fail = 0, n_valid = 0, n_sched = 0;
   int   gp[NO], ap[NI];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [63:0] rq, input logic [3:0] ii, input logic [3:0] oi,
                        input logic [2:0] itr, output exp_t e);
      int lv[NI][NO];
      bit im[NI], om[NO];
      int gs[NO], gl[NO], as_[NI], ab[NI];
      int n, i, o, best;
      bit rem, ai, ao;
      n = (itr == 0) ? 1 : ((int'(itr) > MAX_ITER) ? MAX_ITER : int'(itr));
      e = '0;
      for (int x = 0; x < NI; x++) begin
         im[x] = 0;
         for (int y = 0; y < NO; y++) begin
            lv[x][y] = -1;
            if (ii[x] && oi[y])
               for (int p = 0; p < P; p++)
                  if (rq[x*NO*P + p*NO + y]) lv[x][y] = p;
         end
      end
      for (int y = 0; y < NO; y++) om[y] = 0;
      for (int t = 1; t <= n; t++) begin
         for (int y = 0; y < NO; y++) begin
            gs[y] = -1; gl[y] = -1;
            if (!om[y])
               for (int k = 0; k < NI; k++) begin
                  i = (gp[y] + k) % NI;
                  if (!im[i] && lv[i][y] > gl[y]) begin gl[y] = lv[i][y]; gs[y] = i; end
               end
         end
         for (int x = 0; x < NI; x++) begin
            as_[x] = -1; ab[x] = -1; best = -1;
            if (!im[x])
               for (int k = 0; k < NO; k++) begin
                  o = (ap[x] + k) % NO;
                  if (gs[o] == x && gl[o] > best) begin best = gl[o]; as_[x] = o; ab[x] = gl[o]; end
               end
         end
         for (int x = 0; x < NI; x++)
            if (as_[x] >= 0) begin
               o = as_[x];
               im[x] = 1; om[o] = 1;
               e.m[x*NO + o] = 1'b1;
               e.pr[x*PW +: PW] = PW'(ab[x]);
               if (t == 1) begin gp[o] = (x + 1) % NI; ap[x] = (o + 1) % NO; end
            end
         e.it = 3'(t);
         rem = 0; ai = 1; ao = 1;
         for (int x = 0; x < NI; x++) begin
            if (!im[x]) ai = 0;
            for (int y = 0; y < NO; y++)
               if (lv[x][y] >= 0 && !im[x] && !om[y]) rem = 1;
         end
         for (int y = 0; y < NO; y++) if (!om[y]) ao = 0;
         if (!rem || ai || ao) break;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [NI-1:0] col;
      if (reset && bus.o_valid) begin
         n_valid++;
         if (sb_q.size() == 0) chk("unexpected_valid", 1, 0);
         else begin
            e = sb_q.pop_front();
            chk("match", bus.o_match, e.m);
            chk("match_pri", bus.o_match_pri, e.pr);
            chk("iter_used", bus.o_iter_used, e.it);
         end
         for (int i = 0; i < NI; i++)
            chk("row_onehot", ($countones(bus.o_match[i*NO +: NO]) <= 1), 1);
         for (int o = 0; o < NO; o++) begin
            col = '0;
            for (int i = 0; i < NI; i++) col[i] = bus.o_match[i*NO + o];
            chk("col_onehot", ($countones(col) <= 1), 1);
         end
      end
   end

   task automatic run(input logic [63:0] rq, input logic [3:0] ii, input logic [3:0] oi,
                      input logic [2:0] itr, input bit use_c, input exp_t ce,
                      input int exp_lat, input bit extra);
      exp_t me;
      int   lat;
      model(rq, ii, oi, itr, me);
      sb_q.push_back(use_c ? ce : me);
      n_sched++;
      bus.i_request     = rq;
      bus.i_input_idle  = ii;
      bus.i_output_idle = oi;
      bus.i_iter        = itr;
      bus.i_start       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      bus.i_start       = extra;
      bus.i_request     = {$urandom, $urandom};
      bus.i_input_idle  = 4'($urandom);
      bus.i_output_idle = 4'($urandom);
      bus.i_iter        = 3'($urandom);
      chk("busy_running", bus.o_busy, 1);
      while (!bus.o_valid && lat < 12) begin
         @(negedge clk);
         lat++;
         bus.i_start = 1'b0;
      end
      if (!bus.o_valid) begin
         chk("valid_timeout", 0, 1);
         if (sb_q.size() > 0) void'(sb_q.pop_back());
      end else begin
         chk("busy_in_valid", bus.o_busy, 0);
         if (exp_lat > 0) chk("latency", lat, exp_lat);
      end
      bus.i_start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < NO; k++) gp[k] = 0;
      for (int k = 0; k < NI; k++) ap[k] = 0;
      bus.i_start = 1'b0; bus.i_iter = '0; bus.i_request = '0;
      bus.i_input_idle = '1; bus.i_output_idle = '1;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_match", bus.o_match, 0);
      chk("rst_pri", bus.o_match_pri, 0);
      chk("rst_iter", bus.o_iter_used, 0);
      reset = 1'b1;
      @(negedge clk);

      // uniform level-0 traffic from fresh pointers
      run(ALL0, 4'hF, 4'hF, 3'd3, 1, {16'h0421, 8'h00, 3'd3}, 4, 0);
      chk("g_ptr0", dut.g_ptr[0], 1);
      chk("a_ptr0", dut.a_ptr[0], 1);
      // back-to-back repeat: pointers now desynchronised
      run(ALL0, 4'hF, 4'hF, 3'd3, 1, {16'h8412, 8'h00, 3'd3}, 4, 0);

      // abort mid-schedule with reset
      bus.i_request = ALL0; bus.i_input_idle = '1; bus.i_output_idle = '1;
      bus.i_iter = 3'd4; bus.i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy", bus.o_busy, 0);
      chk("abort_valid", bus.o_valid, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < NO; k++) gp[k] = 0;
      for (int k = 0; k < NI; k++) ap[k] = 0;
      @(negedge clk);
      run(ALL0, 4'hF, 4'hF, 3'd3, 1, {16'h0421, 8'h00, 3'd3}, 4, 0);

      // priority beats pointer order
      run((64'd1 << 6) | (64'd1 << 30), 4'hF, 4'hF, 3'd2, 1, {16'h0040, 8'h0C, 3'd1}, 2, 0);
      // single request terminates early
      run(64'd1 << 35, 4'hF, 4'hF, 3'd4, 1, {16'h0800, 8'h00, 3'd1}, 2, 0);
      // masked output column, extra start while busy
      run(ALL0, 4'hF, 4'b1101, 3'd4, 0, '0, 0, 1);
      chk("out1_col", bus.o_match & 16'h2222, 0);
      // empty schedule
      run(64'd0, 4'hF, 4'hF, 3'd2, 1, {16'h0000, 8'h00, 3'd1}, 2, 0);
      // clamp cases
      run(ALL0, 4'hF, 4'hF, 3'd0, 0, '0, 2, 0);
      run(64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF, 3'd7, 0, '0, 0, 0);

      for (int r = 0; r < 30; r++)
         run({$urandom, $urandom} & {$urandom, $urandom},
             4'($urandom) | 4'($urandom), 4'($urandom) | 4'($urandom),
             3'($urandom), 0, '0, 0, bit'($urandom_range(0, 1)));

      repeat (4) @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);
      chk("valid_count", n_valid, n_sched);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pislip_sched_v2.md
Name: pislip_sched_v2

Overview:
Second-generation prioritised iSLIP crossbar scheduler. It supports a rectangular NI-input by NO-output switch and a per-schedule runtime iteration count. Round-robin grant and accept pointers persist across schedules and update only on first-iteration accepts. Schedules run under a start/valid handshake, with early termination once no matchable request remains. It sits between the VOQ status logic and the crossbar configuration register.

Parameters:
NI, 12, number of input ports
NO, 12, number of output ports
P, 8, priority levels; level P-1 is highest
PW, 3, width of a priority index, clog2(P)
MAX_ITER, 4, maximum iterations per schedule
IW, 3, width of the iteration count, clog2(MAX_ITER+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
i_start  in  1  start a schedule; sampled only when o_busy=0
i_iter  in  IW  requested iterations; 0 is treated as 1; values above MAX_ITER clamp to MAX_ITER
i_request  in  NI*NO*P  request bit index = in*NO*P + p*NO + out
i_input_idle  in  NI  1 = input may be matched
i_output_idle  in  NO  1 = output may be matched
o_busy  out  1  schedule in progress
o_valid  out  1  one-cycle pulse; results valid
o_match  out  NI*NO  bit in*NO+out = pair matched
o_match_pri  out  NI*PW  priority level of each input's match; 0 if the input is unmatched
o_iter_used  out  IW  iterations actually executed

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; o_busy, o_valid, o_match, o_match_pri and o_iter_used all 0; every g_ptr[out] and a_ptr[in] set to 0.
- States and transitions:
  - IDLE: on i_start, capture the request (i_request masked with i_input_idle[in] & i_output_idle[out]) and the clamped iteration count n; clear the match accumulator; go to ITER.
  - ITER: one iteration per cycle; exit as described below.
  - No separate DONE state: the result is registered on the exiting edge.
- Timing: start sampled at edge E0. Iteration i is evaluated in the cycle after E(i-1) and committed at Ei.
  - o_busy=1 from E0 until the final commit.
  - o_valid=1 for exactly the one cycle after the final commit; o_busy=0 in that cycle.
  - An i_start in that cycle is accepted, so back-to-back throughput is n+1 cycles.
- Request phase: only pairs with both input and output still unmatched take part. For each pair, the effective level is the highest p with its request bit set.
- Grant phase: each unmatched output picks the requesting input with the highest level. Ties go round-robin, to the first input at index >= g_ptr[out], modulo NI.
- Accept phase: each unmatched input picks, among its grants, the one with the highest level. Ties go to the first output at index >= a_ptr[in], modulo NO. Accepted pairs are ORed into the match; the level is stored in the input's o_match_pri slot.
- Pointer update (iteration 1 only, accepted pairs only): g_ptr[out] <= (in+1) mod NI and a_ptr[in] <= (out+1) mod NO. Wrap from NI-1 to 0 and from NO-1 to 0. Pointers are unchanged in later iterations and on unaccepted grants.
- Termination after commit of iteration i, on the first of:
  - i == n;
  - no request remains between an unmatched input and an unmatched output;
  - all inputs or all outputs are matched.
  - o_iter_used = i.
- Empty schedule (no requests after masking): one iteration; o_valid with o_match=0 and o_iter_used=1.
- i_start while o_busy=1 is ignored. Input changes during ITER are ignored, since the request was captured at E0.
- Reset mid-schedule: the schedule is aborted, no o_valid is issued, and pointers return to 0.
- Invariant: o_match has at most one bit per input row and at most one bit per output column.

Decomposition:
- Shared package pislip_pkg: state encoding (IDLE, ITER), clog2 function, request-bit index helper.
- Natural sub-module: prio_rr_arbiter, parametrised on W and P. It takes a W-way request, a per-requester level and a pointer, and returns a one-hot winner plus the winning level. Instantiate NO of them for grant and NI for accept.

Test Plan:
1. Assert reset mid-ITER -> o_busy=0 immediately; no o_valid; next schedule behaves as from pointers 0.
2. NI=NO=4, P=4, all pairs request at level 0, i_iter=3 -> o_valid 4 cycles after start. o_match has in0-out0, in1-out1 and in2-out2; in3 unmatched; o_iter_used=3. Afterwards g_ptr[0]=1 and a_ptr[0]=1.
3. Repeat scenario 2 immediately, i_start during o_valid -> accepted. Iteration 1 gives in0-out1 and in1-out0, showing pointer desynchronisation.
4. in0->out2 at level 1 and in1->out2 at level 3 -> in1-out2 matched; o_match_pri[in1]=3; in0 unmatched.
5. Single request in2->out3, i_iter=4 -> early termination: o_iter_used=1; o_valid 2 cycles after start.
6. All-to-all requests with i_output_idle[1]=0, plus i_start pulsed while o_busy -> out1 column all zeros; the second start has no effect; exactly one o_valid.
